// File: rtl/rv32_decode_execute_pkg.sv
// Shared encodings for the RV32I decode/execute slice: opcodes, funct fields,
// ALU operations, memory/CSR side-effect codes and the ALU helper functions.
package rv32_decode_execute_pkg;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_SLTU = 3'b011;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_SR   = 3'b101;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  localparam logic [2:0] F3_JALR  = 3'b000;
  localparam logic [2:0] F3_PRIV  = 3'b000;
  localparam logic [2:0] F3_CSRRW = 3'b001;
  localparam logic [2:0] F3_CSRRS = 3'b010;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
    ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND
  } alu_op_e;

  localparam logic [2:0] LD_NONE = 3'd0;
  localparam logic [2:0] LD_B    = 3'd1;
  localparam logic [2:0] LD_H    = 3'd2;
  localparam logic [2:0] LD_W    = 3'd3;
  localparam logic [2:0] LD_BU   = 3'd4;
  localparam logic [2:0] LD_HU   = 3'd5;

  localparam logic [1:0] ST_NONE = 2'd0;
  localparam logic [1:0] ST_B    = 2'd1;
  localparam logic [1:0] ST_H    = 2'd2;
  localparam logic [1:0] ST_W    = 2'd3;

  localparam logic [2:0] CSR_NONE  = 3'b000;
  localparam logic [2:0] CSR_RW    = 3'b001;
  localparam logic [2:0] CSR_RS    = 3'b010;
  localparam logic [2:0] CSR_ECALL = 3'b100;
  localparam logic [2:0] CSR_MRET  = 3'b101;

  localparam logic [31:0] MCAUSE_ECALL = 32'd11;
  localparam logic [31:0] INST_ECALL   = 32'h0000_0073;
  localparam logic [31:0] INST_EBREAK  = 32'h0010_0073;
  localparam logic [31:0] INST_MRET    = 32'h3020_0073;

  // alt selects sub/sra on the two funct3 codes that have an alternate form
  function automatic alu_op_e alu_op_from(input logic [2:0] f3, input logic alt);
    case (f3)
      F3_ADD:  return alt ? ALU_SUB : ALU_ADD;
      F3_SLL:  return ALU_SLL;
      F3_SLT:  return ALU_SLT;
      F3_SLTU: return ALU_SLTU;
      F3_XOR:  return ALU_XOR;
      F3_SR:   return alt ? ALU_SRA : ALU_SRL;
      F3_OR:   return ALU_OR;
      F3_AND:  return ALU_AND;
      default: return ALU_ADD;
    endcase
  endfunction

  function automatic logic [31:0] alu_compute(input alu_op_e op, input logic [31:0] a,
                                              input logic [31:0] b);
    case (op)
      ALU_ADD:  return a + b;
      ALU_SUB:  return a - b;
      ALU_SLL:  return a << b[4:0];
      ALU_SLT:  return {31'b0, $signed(a) < $signed(b)};
      ALU_SLTU: return {31'b0, a < b};
      ALU_XOR:  return a ^ b;
      ALU_SRL:  return a >> b[4:0];
      ALU_SRA:  return 32'($signed(a) >>> b[4:0]);
      ALU_OR:   return a | b;
      ALU_AND:  return a & b;
      default:  return a + b;
    endcase
  endfunction

endpackage

// File: rtl/rv32_decode_execute_regfile.sv
// 32x32 integer register file: two combinational read ports, one write port,
// asynchronous active-low clear. x0 is never written and always reads zero.
module rv32_regfile
  #(parameter int DATA_LEN = 32)
  (
    input  logic                clk,
    input  logic                rst,
    input  logic [4:0]          raddr1,
    input  logic [4:0]          raddr2,
    input  logic                wen,
    input  logic [4:0]          waddr,
    input  logic [DATA_LEN-1:0] wdata,
    output logic [DATA_LEN-1:0] rdata1,
    output logic [DATA_LEN-1:0] rdata2
  );

  logic [DATA_LEN-1:0] regs [32];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 32; i++) regs[i] <= '0;
    end else if (wen && waddr != 5'd0) begin
      regs[waddr] <= wdata;
    end
  end

  // No write bypass: a same-cycle read of waddr sees the pre-edge value
  assign rdata1 = (raddr1 == 5'd0) ? '0 : regs[raddr1];
  assign rdata2 = (raddr2 == 5'd0) ? '0 : regs[raddr2];

endmodule

// File: rtl/rv32_decode_execute.sv
// Single-cycle RV32I (+Zicsr, ecall/mret/ebreak) decode, register read and
// execute slice. All outputs are combinational from the fetched instruction.
module rv32_decode_execute
  import rv32_decode_execute_pkg::*;
  #(parameter int DATA_LEN = 32,
    parameter int ADDR_LEN = 32)
  (
    input  logic                clk,
    input  logic                rst,
    input  logic                ifu_valid,
    input  logic [31:0]         inst_i,
    input  logic [ADDR_LEN-1:0] pc_i,
    input  logic                reg_wen_i,
    input  logic [4:0]          reg_waddr_i,
    input  logic [DATA_LEN-1:0] reg_wdata_i,
    input  logic [DATA_LEN-1:0] csr_rdata_i,
    output logic [11:0]         csr_addr_o,
    output logic                branch_request_o,
    output logic [ADDR_LEN-1:0] branch_target_o,
    output logic                jmp_flag_o,
    output logic [ADDR_LEN-1:0] jmp_target_o,
    output logic [2:0]          csr_flag_o,
    output logic                wd_o,
    output logic [4:0]          wreg_o,
    output logic [DATA_LEN-1:0] alu_result_o,
    output logic                mem_wen_o,
    output logic [DATA_LEN-1:0] mem_wdata_o,
    output logic [2:0]          load_type_o,
    output logic [1:0]          store_type_o,
    output logic [DATA_LEN-1:0] csr_wdata_o,
    output logic [DATA_LEN-1:0] csr_mcause_o,
    output logic [ADDR_LEN-1:0] pc_o,
    output logic                invalid_o,
    output logic                ebreak_o
  );

  logic [6:0] opcode, funct7;
  logic [2:0] funct3;
  logic [4:0] rd, rs1_addr, rs2_addr;
  logic [31:0] rs1, rs2;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j, jalr_sum;

  assign opcode   = inst_i[6:0];
  assign rd       = inst_i[11:7];
  assign funct3   = inst_i[14:12];
  assign rs1_addr = inst_i[19:15];
  assign rs2_addr = inst_i[24:20];
  assign funct7   = inst_i[31:25];

  rv32_regfile #(.DATA_LEN(DATA_LEN)) u_regfile (
    .clk    (clk),
    .rst    (rst),
    .raddr1 (rs1_addr),
    .raddr2 (rs2_addr),
    .wen    (reg_wen_i),
    .waddr  (reg_waddr_i),
    .wdata  (reg_wdata_i),
    .rdata1 (rs1),
    .rdata2 (rs2)
  );

  assign imm_i = {{20{inst_i[31]}}, inst_i[31:20]};
  assign imm_s = {{20{inst_i[31]}}, inst_i[31:25], inst_i[11:7]};
  assign imm_b = {{19{inst_i[31]}}, inst_i[31], inst_i[7], inst_i[30:25], inst_i[11:8], 1'b0};
  assign imm_u = {inst_i[31:12], 12'b0};
  assign imm_j = {{11{inst_i[31]}}, inst_i[31], inst_i[19:12], inst_i[20], inst_i[30:21], 1'b0};
  assign jalr_sum = rs1 + imm_i;

  alu_op_e     alu_op;
  logic [31:0] op_a, op_b, csr_wdata;
  logic [2:0]  ld, csr_flag;
  logic [1:0]  st;
  logic        use_csr, wd, mem_wen, br_cond, jmp, inv, ebrk, ecall;

  always_comb begin
    alu_op    = ALU_ADD;
    op_a      = '0;
    op_b      = '0;
    csr_wdata = '0;
    ld        = LD_NONE;
    st        = ST_NONE;
    csr_flag  = CSR_NONE;
    use_csr   = 1'b0;
    wd        = 1'b0;
    mem_wen   = 1'b0;
    br_cond   = 1'b0;
    jmp       = 1'b0;
    inv       = 1'b0;
    ebrk      = 1'b0;
    ecall     = 1'b0;
    case (opcode)
      OPC_OP: begin
        op_a = rs1;
        op_b = rs2;
        wd   = 1'b1;
        if (funct7 == F7_BASE) alu_op = alu_op_from(funct3, 1'b0);
        else if (funct7 == F7_ALT && (funct3 == F3_ADD || funct3 == F3_SR))
          alu_op = alu_op_from(funct3, 1'b1);
        else inv = 1'b1;
      end
      OPC_OP_IMM: begin
        op_a = rs1;
        op_b = imm_i;
        wd   = 1'b1;
        // only the shift forms constrain the upper immediate bits
        if (funct3 == F3_SLL) begin
          alu_op = ALU_SLL;
          inv    = (funct7 != F7_BASE);
        end else if (funct3 == F3_SR) begin
          alu_op = alu_op_from(funct3, funct7 == F7_ALT);
          inv    = (funct7 != F7_BASE) && (funct7 != F7_ALT);
        end else begin
          alu_op = alu_op_from(funct3, 1'b0);
        end
      end
      OPC_LUI:   begin op_b = imm_u; wd = 1'b1; end
      OPC_AUIPC: begin op_a = pc_i; op_b = imm_u; wd = 1'b1; end
      OPC_JAL:   begin op_a = pc_i; op_b = 32'd4; wd = 1'b1; jmp = 1'b1; end
      OPC_JALR: begin
        op_a = pc_i;
        op_b = 32'd4;
        wd   = 1'b1;
        jmp  = 1'b1;
        inv  = (funct3 != F3_JALR);
      end
      OPC_BRANCH: begin
        case (funct3)
          F3_BEQ:  br_cond = (rs1 == rs2);
          F3_BNE:  br_cond = (rs1 != rs2);
          F3_BLT:  br_cond = ($signed(rs1) <  $signed(rs2));
          F3_BGE:  br_cond = ($signed(rs1) >= $signed(rs2));
          F3_BLTU: br_cond = (rs1 <  rs2);
          F3_BGEU: br_cond = (rs1 >= rs2);
          default: inv = 1'b1;
        endcase
      end
      OPC_LOAD: begin
        op_a = rs1;
        op_b = imm_i;
        wd   = 1'b1;
        case (funct3)
          F3_LB:   ld = LD_B;
          F3_LH:   ld = LD_H;
          F3_LW:   ld = LD_W;
          F3_LBU:  ld = LD_BU;
          F3_LHU:  ld = LD_HU;
          default: inv = 1'b1;
        endcase
      end
      OPC_STORE: begin
        op_a    = rs1;
        op_b    = imm_s;
        mem_wen = 1'b1;
        case (funct3)
          F3_SB:   st = ST_B;
          F3_SH:   st = ST_H;
          F3_SW:   st = ST_W;
          default: inv = 1'b1;
        endcase
      end
      OPC_SYSTEM: begin
        case (funct3)
          F3_CSRRW: begin
            use_csr = 1'b1; wd = 1'b1; csr_flag = CSR_RW; csr_wdata = rs1;
          end
          F3_CSRRS: begin
            use_csr = 1'b1; wd = 1'b1; csr_flag = CSR_RS; csr_wdata = csr_rdata_i | rs1;
          end
          F3_PRIV: begin
            if (inst_i == INST_ECALL) begin
              csr_flag = CSR_ECALL;
              ecall    = 1'b1;
            end else if (inst_i == INST_MRET) csr_flag = CSR_MRET;
            else if (inst_i == INST_EBREAK) ebrk = 1'b1;
            else inv = 1'b1;
          end
          default: inv = 1'b1;
        endcase
      end
      default: inv = 1'b1;
    endcase
    if (inv) begin
      wd       = 1'b0;
      mem_wen  = 1'b0;
      ld       = LD_NONE;
      st       = ST_NONE;
      br_cond  = 1'b0;
      jmp      = 1'b0;
      use_csr  = 1'b0;
      csr_flag = CSR_NONE;
    end
  end

  assign alu_result_o = inv ? '0 : (use_csr ? csr_rdata_i : alu_compute(alu_op, op_a, op_b));

  assign csr_addr_o      = inst_i[31:20];
  assign wreg_o          = rd;
  assign mem_wdata_o     = rs2;
  assign pc_o            = pc_i;
  assign csr_wdata_o     = csr_wdata;
  assign branch_target_o = pc_i + imm_b;
  assign jmp_target_o    = (opcode == OPC_JALR) ? {jalr_sum[31:1], 1'b0} : pc_i + imm_j;

  assign wd_o             = wd & ifu_valid;
  assign mem_wen_o        = mem_wen & ifu_valid;
  assign branch_request_o = br_cond & ifu_valid;
  assign jmp_flag_o       = jmp & ifu_valid;
  assign csr_flag_o       = ifu_valid ? csr_flag : CSR_NONE;
  assign load_type_o      = ifu_valid ? ld : LD_NONE;
  assign store_type_o     = ifu_valid ? st : ST_NONE;
  assign invalid_o        = inv & ifu_valid;
  assign ebreak_o         = ebrk & ifu_valid;
  assign csr_mcause_o     = (ecall && ifu_valid) ? MCAUSE_ECALL : '0;

endmodule

// File: tb/tb_rv32_decode_execute.sv
// Bench for rv32_decode_execute: directed plan steps plus randomized
// instructions checked against an instruction-level reference model.
module tb_rv32_decode_execute;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        ifu_valid = 1'b0;
  logic [31:0] inst_i = 32'h0000_0013;
  logic [31:0] pc_i = '0;
  logic        reg_wen_i = 1'b0;
  logic [4:0]  reg_waddr_i = '0;
  logic [31:0] reg_wdata_i = '0;
  logic [31:0] csr_rdata_i = '0;
  logic [11:0] csr_addr_o;
  logic        branch_request_o, jmp_flag_o, wd_o, mem_wen_o, invalid_o, ebreak_o;
  logic [31:0] branch_target_o, jmp_target_o, alu_result_o, mem_wdata_o;
  logic [31:0] csr_wdata_o, csr_mcause_o, pc_o;
  logic [2:0]  csr_flag_o, load_type_o;
  logic [1:0]  store_type_o;
  logic [4:0]  wreg_o;

  int total = 0;
  int bad = 0;
  logic [31:0] m_regs [32];

  always #5 clk = ~clk;

  rv32_decode_execute dut (
    .clk(clk), .rst(rst), .ifu_valid(ifu_valid), .inst_i(inst_i), .pc_i(pc_i),
    .reg_wen_i(reg_wen_i), .reg_waddr_i(reg_waddr_i), .reg_wdata_i(reg_wdata_i),
    .csr_rdata_i(csr_rdata_i), .csr_addr_o(csr_addr_o),
    .branch_request_o(branch_request_o), .branch_target_o(branch_target_o),
    .jmp_flag_o(jmp_flag_o), .jmp_target_o(jmp_target_o), .csr_flag_o(csr_flag_o),
    .wd_o(wd_o), .wreg_o(wreg_o), .alu_result_o(alu_result_o), .mem_wen_o(mem_wen_o),
    .mem_wdata_o(mem_wdata_o), .load_type_o(load_type_o), .store_type_o(store_type_o),
    .csr_wdata_o(csr_wdata_o), .csr_mcause_o(csr_mcause_o), .pc_o(pc_o),
    .invalid_o(invalid_o), .ebreak_o(ebreak_o)
  );

  typedef struct packed {
    logic        wd;
    logic [31:0] alu;
    logic        mem_wen;
    logic [2:0]  ld;
    logic [1:0]  st;
    logic        br_req;
    logic        jmp;
    logic [31:0] jmp_tgt;
    logic [2:0]  csr_flag;
    logic [31:0] csr_wdata;
    logic [31:0] mcause;
    logic        inv;
    logic        ebrk;
  } exp_t;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd,
                                        input logic [6:0] op);
    return {imm, rs1, f3, rd, op};
  endfunction

  function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3,
                                        input logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, 7'h33};
  endfunction

  function automatic logic [31:0] enc_s(input logic [11:0] imm, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3);
    return {imm[11:5], rs2, rs1, f3, imm[4:0], 7'h23};
  endfunction

  function automatic logic [31:0] enc_b(input logic [12:0] imm, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3);
    return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'h63};
  endfunction

  function automatic logic [31:0] enc_j(input logic [20:0] imm, input logic [4:0] rd);
    return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'h6F};
  endfunction

  // Instruction-level reference: what each mnemonic does to the architectural outputs
  function automatic exp_t model(input logic [31:0] inst, input logic [31:0] pc,
                                 input logic [31:0] csr_r, input logic valid);
    exp_t e;
    logic [31:0] a, b, ii, is, iu, ij;
    logic [6:0] f7;
    logic [2:0] f3;
    logic badi;
    e = '0;
    badi = 1'b0;
    a  = m_regs[inst[19:15]];
    b  = m_regs[inst[24:20]];
    f3 = inst[14:12];
    f7 = inst[31:25];
    ii = 32'($signed(inst[31:20]));
    is = 32'($signed({inst[31:25], inst[11:7]}));
    iu = {inst[31:12], 12'h000};
    ij = 32'($signed({inst[31], inst[19:12], inst[20], inst[30:21], 1'b0}));
    case (inst[6:0])
      7'h33: begin
        e.wd = 1'b1;
        case ({f7, f3})
          {7'h00, 3'd0}: e.alu = a + b;
          {7'h20, 3'd0}: e.alu = a - b;
          {7'h00, 3'd1}: e.alu = a << b[4:0];
          {7'h00, 3'd2}: e.alu = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
          {7'h00, 3'd3}: e.alu = (a < b) ? 32'd1 : 32'd0;
          {7'h00, 3'd4}: e.alu = a ^ b;
          {7'h00, 3'd5}: e.alu = a >> b[4:0];
          {7'h20, 3'd5}: e.alu = 32'($signed(a) >>> b[4:0]);
          {7'h00, 3'd6}: e.alu = a | b;
          {7'h00, 3'd7}: e.alu = a & b;
          default: badi = 1'b1;
        endcase
      end
      7'h13: begin
        e.wd = 1'b1;
        case (f3)
          3'd0: e.alu = a + ii;
          3'd1: if (f7 == 7'h00) e.alu = a << ii[4:0]; else badi = 1'b1;
          3'd2: e.alu = ($signed(a) < $signed(ii)) ? 32'd1 : 32'd0;
          3'd3: e.alu = (a < ii) ? 32'd1 : 32'd0;
          3'd4: e.alu = a ^ ii;
          3'd5: if (f7 == 7'h00) e.alu = a >> ii[4:0];
                else if (f7 == 7'h20) e.alu = 32'($signed(a) >>> ii[4:0]);
                else badi = 1'b1;
          3'd6: e.alu = a | ii;
          default: e.alu = a & ii;
        endcase
      end
      7'h37: begin e.wd = 1'b1; e.alu = iu; end
      7'h17: begin e.wd = 1'b1; e.alu = pc + iu; end
      7'h6F: begin e.wd = 1'b1; e.jmp = 1'b1; e.alu = pc + 32'd4; e.jmp_tgt = pc + ij; end
      7'h67: begin
        if (f3 == 3'd0) begin
          e.wd = 1'b1; e.jmp = 1'b1; e.alu = pc + 32'd4;
          e.jmp_tgt = (a + ii) & 32'hFFFF_FFFE;
        end else badi = 1'b1;
      end
      7'h63: begin
        case (f3)
          3'd0: e.br_req = (a == b);
          3'd1: e.br_req = (a != b);
          3'd4: e.br_req = ($signed(a) < $signed(b));
          3'd5: e.br_req = ($signed(a) >= $signed(b));
          3'd6: e.br_req = (a < b);
          3'd7: e.br_req = (a >= b);
          default: badi = 1'b1;
        endcase
      end
      7'h03: begin
        e.wd = 1'b1; e.alu = a + ii;
        case (f3)
          3'd0: e.ld = 3'd1;
          3'd1: e.ld = 3'd2;
          3'd2: e.ld = 3'd3;
          3'd4: e.ld = 3'd4;
          3'd5: e.ld = 3'd5;
          default: badi = 1'b1;
        endcase
      end
      7'h23: begin
        e.mem_wen = 1'b1; e.alu = a + is;
        if (f3 <= 3'd2) e.st = 2'(f3 + 3'd1); else badi = 1'b1;
      end
      7'h73: begin
        if (f3 == 3'd1) begin
          e.wd = 1'b1; e.alu = csr_r; e.csr_flag = 3'b001; e.csr_wdata = a;
        end else if (f3 == 3'd2) begin
          e.wd = 1'b1; e.alu = csr_r; e.csr_flag = 3'b010; e.csr_wdata = csr_r | a;
        end else if (inst == 32'h0000_0073) begin
          e.csr_flag = 3'b100; e.mcause = 32'd11;
        end else if (inst == 32'h3020_0073) e.csr_flag = 3'b101;
        else if (inst == 32'h0010_0073) e.ebrk = 1'b1;
        else badi = 1'b1;
      end
      default: badi = 1'b1;
    endcase
    if (badi) begin
      e = '0;
      e.inv = 1'b1;
    end
    if (!valid) begin
      e.wd = 1'b0; e.mem_wen = 1'b0; e.br_req = 1'b0; e.jmp = 1'b0; e.csr_flag = 3'b000;
      e.ld = 3'd0; e.st = 2'd0; e.inv = 1'b0; e.ebrk = 1'b0; e.mcause = '0;
    end
    return e;
  endfunction

  task automatic exec(input string tag, input logic [31:0] inst, input logic [31:0] pc,
                      input logic [31:0] csr_r, input logic valid);
    exp_t e;
    logic [31:0] bimm;
    @(negedge clk);
    inst_i = inst; pc_i = pc; csr_rdata_i = csr_r; ifu_valid = valid;
    #1;
    e = model(inst, pc, csr_r, valid);
    bimm = 32'($signed({inst[31], inst[7], inst[30:25], inst[11:8], 1'b0}));
    chk({tag, ".wd"},        32'(wd_o), 32'(e.wd));
    chk({tag, ".wreg"},      32'(wreg_o), 32'(inst[11:7]));
    chk({tag, ".alu"},       alu_result_o, e.alu);
    chk({tag, ".mem_wen"},   32'(mem_wen_o), 32'(e.mem_wen));
    chk({tag, ".mem_wdata"}, mem_wdata_o, m_regs[inst[24:20]]);
    chk({tag, ".ld"},        32'(load_type_o), 32'(e.ld));
    chk({tag, ".st"},        32'(store_type_o), 32'(e.st));
    chk({tag, ".br_req"},    32'(branch_request_o), 32'(e.br_req));
    chk({tag, ".br_tgt"},    branch_target_o, pc + bimm);
    chk({tag, ".jmp"},       32'(jmp_flag_o), 32'(e.jmp));
    if (e.jmp) chk({tag, ".jmp_tgt"}, jmp_target_o, e.jmp_tgt);
    chk({tag, ".csr_flag"},  32'(csr_flag_o), 32'(e.csr_flag));
    chk({tag, ".csr_wdata"}, csr_wdata_o, e.csr_wdata);
    chk({tag, ".mcause"},    csr_mcause_o, e.mcause);
    chk({tag, ".csr_addr"},  32'(csr_addr_o), 32'(inst[31:20]));
    chk({tag, ".pc"},        pc_o, pc);
    chk({tag, ".invalid"},   32'(invalid_o), 32'(e.inv));
    chk({tag, ".ebreak"},    32'(ebreak_o), 32'(e.ebrk));
  endtask

  task automatic wb(input logic [4:0] addr, input logic [31:0] data);
    @(negedge clk);
    reg_wen_i = 1'b1; reg_waddr_i = addr; reg_wdata_i = data;
    @(posedge clk);
    if (rst && addr != 5'd0) m_regs[addr] = data;
    #1;
    reg_wen_i = 1'b0;
  endtask

  function automatic logic [31:0] rand_val();
    case ($urandom_range(0, 5))
      0: return 32'hFFFF_FFFF;
      1: return 32'h8000_0000;
      2: return 32'($urandom_range(0, 40));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    logic [31:0] inst, pc;
    logic [4:0] rd, r1, r2;
    logic [2:0] f3;
    for (int i = 0; i < 32; i++) m_regs[i] = '0;

    // reset held: reads are zero and writes are blocked
    exec("rst_read", enc_i(12'd0, 5'd9, 3'd0, 5'd5, 7'h13), 32'h0, 32'h0, 1'b1);
    wb(5'd9, 32'h1234_5678);
    exec("rst_wblock", enc_i(12'd0, 5'd9, 3'd0, 5'd5, 7'h13), 32'h0, 32'h0, 1'b1);
    chk("rst_wblock_val", alu_result_o, 32'h0);
    @(negedge clk);
    rst = 1'b1;

    exec("addi", enc_i(12'd5, 5'd0, 3'd0, 5'd1, 7'h13), 32'h8000_0000, 32'h0, 1'b1);
    chk("addi_val", alu_result_o, 32'd5);
    wb(5'd1, 32'd5);
    exec("add", enc_r(7'h00, 5'd1, 5'd1, 3'd0, 5'd2), 32'h8000_0004, 32'h0, 1'b1);
    chk("add_val", alu_result_o, 32'd10);
    wb(5'd2, 32'd10);
    exec("read_x2", enc_i(12'd0, 5'd2, 3'd0, 5'd3, 7'h13), 32'h8000_0008, 32'h0, 1'b1);
    chk("read_x2_val", alu_result_o, 32'd10);
    wb(5'd0, 32'd7);
    exec("read_x0", enc_r(7'h00, 5'd0, 5'd0, 3'd0, 5'd3), 32'h8000_000C, 32'h0, 1'b1);
    chk("read_x0_val", alu_result_o, 32'd0);

    exec("beq", enc_b(13'h1FF8, 5'd1, 5'd1, 3'd0), 32'h8000_0010, 32'h0, 1'b1);
    chk("beq_req", 32'(branch_request_o), 32'd1);
    chk("beq_tgt", branch_target_o, 32'h8000_0008);
    wb(5'd6, 32'hFFFF_FFFF);
    wb(5'd7, 32'd1);
    exec("bltu", enc_b(13'd16, 5'd7, 5'd6, 3'b110), 32'h8000_0014, 32'h0, 1'b1);
    chk("bltu_req", 32'(branch_request_o), 32'd0);
    exec("blt", enc_b(13'd16, 5'd7, 5'd6, 3'b100), 32'h8000_0018, 32'h0, 1'b1);
    chk("blt_req", 32'(branch_request_o), 32'd1);

    wb(5'd2, 32'h8000_0003);
    exec("jalr", enc_i(12'd4, 5'd2, 3'd0, 5'd1, 7'h67), 32'h8000_0000, 32'h0, 1'b1);
    chk("jalr_tgt", jmp_target_o, 32'h8000_0006);
    chk("jalr_link", alu_result_o, 32'h8000_0004);

    wb(5'd4, 32'h100);
    wb(5'd3, 32'hCAFE_F00D);
    exec("sw", enc_s(12'd8, 5'd3, 5'd4, 3'b010), 32'h8000_0020, 32'h0, 1'b1);
    chk("sw_wen", 32'(mem_wen_o), 32'd1);
    chk("sw_addr", alu_result_o, 32'h108);
    chk("sw_type", 32'(store_type_o), 32'd3);
    chk("sw_wd", 32'(wd_o), 32'd0);
    exec("lhu", enc_i(12'd0, 5'd4, 3'b101, 5'd5, 7'h03), 32'h8000_0024, 32'h0, 1'b1);
    chk("lhu_type", 32'(load_type_o), 32'd5);

    wb(5'd8, 32'h0F);
    exec("csrrs", enc_i(12'h300, 5'd8, 3'b010, 5'd5, 7'h73), 32'h8000_0028, 32'hF0, 1'b1);
    chk("csrrs_wdata", csr_wdata_o, 32'hFF);
    chk("csrrs_rd", alu_result_o, 32'hF0);
    exec("ecall", 32'h0000_0073, 32'h8000_002C, 32'h0, 1'b1);
    chk("ecall_flag", 32'(csr_flag_o), 32'b100);
    chk("ecall_cause", csr_mcause_o, 32'd11);
    exec("mret", 32'h3020_0073, 32'h8000_0030, 32'h0, 1'b1);
    exec("ebreak", 32'h0010_0073, 32'h8000_0034, 32'h0, 1'b1);

    exec("sw_novalid", enc_s(12'd8, 5'd3, 5'd4, 3'b010), 32'h8000_0038, 32'h0, 1'b0);
    chk("sw_novalid_wen", 32'(mem_wen_o), 32'd0);
    exec("opc7f", 32'h0000_007F, 32'h8000_003C, 32'h0, 1'b1);
    chk("opc7f_inv", 32'(invalid_o), 32'd1);

    // same-edge write and read of one register returns the old value
    @(negedge clk);
    inst_i = enc_i(12'd0, 5'd8, 3'd0, 5'd5, 7'h13);
    ifu_valid = 1'b1;
    reg_wen_i = 1'b1; reg_waddr_i = 5'd8; reg_wdata_i = 32'h5555_AAAA;
    #1;
    chk("no_bypass", alu_result_o, 32'h0F);
    @(posedge clk);
    m_regs[8] = 32'h5555_AAAA;
    #1;
    reg_wen_i = 1'b0;
    exec("after_wr", enc_i(12'd0, 5'd8, 3'd0, 5'd5, 7'h13), 32'h0, 32'h0, 1'b1);

    for (int i = 1; i < 32; i++) wb(5'(i), rand_val());

    for (int n = 0; n < 300; n++) begin
      if (n % 5 == 0) wb(5'($urandom_range(0, 31)), rand_val());
      rd = 5'($urandom_range(0, 31));
      r1 = 5'($urandom_range(0, 31));
      r2 = 5'($urandom_range(0, 31));
      f3 = 3'($urandom_range(0, 7));
      pc = $urandom & 32'hFFFF_FFFC;
      case ($urandom_range(0, 11))
        0: inst = enc_r(($urandom_range(0, 7) == 0) ? 7'($urandom) :
                        (($urandom_range(0, 2) == 0) ? 7'h20 : 7'h00), r2, r1, f3, rd);
        1: inst = enc_i((f3 == 3'd1 || f3 == 3'd5) ?
                        {(($urandom_range(0, 1) == 0) ? 7'h20 : 7'($urandom_range(0, 1))),
                         5'($urandom)} : 12'($urandom), r1, f3, rd, 7'h13);
        2: inst = enc_i(12'($urandom), r1, f3, rd, 7'h03);
        3: inst = enc_s(12'($urandom), r2, r1, f3);
        4: inst = enc_b(13'($urandom), r2, r1, f3);
        5: inst = {20'($urandom), rd, 7'h37};
        6: inst = {20'($urandom), rd, 7'h17};
        7: inst = enc_j(21'($urandom), rd);
        8: inst = enc_i(12'($urandom), r1, ($urandom_range(0, 3) == 0) ? f3 : 3'd0, rd, 7'h67);
        9: inst = enc_i(12'($urandom), r1, 3'($urandom_range(1, 2)), rd, 7'h73);
        10: case ($urandom_range(0, 3))
              0: inst = 32'h0000_0073;
              1: inst = 32'h3020_0073;
              2: inst = 32'h0010_0073;
              default: inst = enc_i(12'($urandom), r1, f3, rd, 7'h73);
            endcase
        default: inst = $urandom;
      endcase
      exec($sformatf("rnd%0d", n), inst, pc, rand_val(), $urandom_range(0, 9) != 0);
    end

    // asynchronous reset between clock edges clears every register at once
    wb(5'd9, 32'hDEAD_BEEF);
    @(negedge clk);
    inst_i = enc_i(12'd0, 5'd9, 3'd0, 5'd5, 7'h13);
    ifu_valid = 1'b1;
    #2;
    rst = 1'b0;
    #1;
    chk("async_rst", alu_result_o, 32'h0);
    for (int i = 0; i < 32; i++) m_regs[i] = '0;
    for (int i = 1; i < 32; i += 5)
      exec($sformatf("rst_x%0d", i), enc_i(12'd0, 5'(i), 3'd0, 5'd5, 7'h13), 32'h0, 32'h0, 1'b1);
    @(negedge clk);
    rst = 1'b1;
    wb(5'd9, 32'h0000_0042);
    exec("post_rst_wr", enc_i(12'd0, 5'd9, 3'd0, 5'd5, 7'h13), 32'h0, 32'h0, 1'b1);
    chk("post_rst_val", alu_result_o, 32'h42);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/rv32_decode_execute.md
# rv32_decode_execute

Single-cycle RV32I (+Zicsr, ecall/mret/ebreak) decode/register-read/execute slice between the IFU and the LSU/WB stages. Holds the 32×32 integer register file. Decodes the fetched instruction and computes ALU, branch, jump, memory-request and CSR results combinationally. Receives the write-back port from WB.

## Interface
- Parameters: `DATA_LEN`, 32, datapath width; `ADDR_LEN`, 32, PC width.
- Clock and reset:
  - `clk` in 1: the single clock.
  - `rst` in 1: asynchronous, active-low reset.
- Fetch and write-back inputs:
  - `ifu_valid` in 1: instruction valid.
  - `inst_i` in 32: instruction word.
  - `pc_i` in 32: PC of `inst_i`.
  - `reg_wen_i` in 1, `reg_waddr_i` in 5, `reg_wdata_i` in 32: write-back port.
- CSR inputs:
  - `csr_rdata_i` in 32: value of the addressed CSR.
- Control outputs:
  - `csr_addr_o` out 12: `inst[31:20]`.
  - `branch_request_o` out 1, `branch_target_o` out 32.
  - `jmp_flag_o` out 1, `jmp_target_o` out 32.
  - `csr_flag_o` out 3: 000 none, 001 csrrw, 010 csrrs, 100 ecall, 101 mret. Bit 2 means redirect the PC to the CSR unit's PC.
- Data-path outputs:
  - `wd_o` out 1, `wreg_o` out 5: rd write enable and rd.
  - `alu_result_o` out 32: rd value or memory address.
  - `mem_wen_o` out 1, `mem_wdata_o` out 32: store request and rs2.
  - `load_type_o` out 3: 0 none, 1 lb, 2 lh, 3 lw, 4 lbu, 5 lhu.
  - `store_type_o` out 2: 0 none, 1 sb, 2 sh, 3 sw.
- CSR and status outputs:
  - `csr_wdata_o` out 32, `csr_mcause_o` out 32, `pc_o` out 32 (mepc source, equals `pc_i`).
  - `invalid_o` out 1: unrecognised instruction.
  - `ebreak_o` out 1: ebreak decoded.

## Operation
- Register file:
  - x0 always reads 0.
  - Writes are ignored when `reg_waddr_i`=0.
  - Reads of rs1=`inst[19:15]` and rs2=`inst[24:20]` are combinational.
  - A read of the address being written in the same cycle returns the old value (no bypass).
- Immediates: standard I/S/B/U/J formats, sign-extended to 32 bits.
- ALU, with `alu_result_o` as follows:
  - add, sub, sll, slt, sltu, xor, srl, sra, or, and: reg-reg or reg-imm. Shift amount is operand B[4:0].
  - lui: imm.
  - auipc: pc+imm.
  - jal/jalr: pc+4.
  - loads/stores: rs1+imm.
  - csrrw/csrrs: `csr_rdata_i`.
- `wd_o`=1 for all rd-writing classes. It is 0 for stores, branches, ecall, mret, ebreak and invalid instructions.
- Branches: `branch_target_o`=pc+imm_B. `branch_request_o`=1 iff the condition holds, using signed compare for blt/bge and unsigned for bltu/bgeu.
- Jumps: `jmp_flag_o`=1 for jal/jalr. Target is pc+imm_J for jal, (rs1+imm_I)&~1 for jalr.
- CSR instructions:
  - csrrw: `csr_wdata_o`=rs1.
  - csrrs: `csr_wdata_o`=`csr_rdata_i`|rs1.
  - ecall: `csr_mcause_o`=32'd11. `csr_mcause_o` is 0 otherwise.
- Gating: when `ifu_valid`=0, the following are all 0: `wd_o`, `mem_wen_o`, `branch_request_o`, `jmp_flag_o`, `csr_flag_o`, `load_type_o`, `store_type_o`, `invalid_o`, `ebreak_o`.
- Unknown opcode or funct: `invalid_o`=1 and every side-effect output is 0.

## Timing
- All outputs are combinational from `inst_i`, `pc_i`, register contents, `csr_rdata_i` and `ifu_valid`. Latency is 0 cycles.
- A register write completes at the `clk` rising edge when `reg_wen_i`=1.
- Reset clears all 32 registers immediately, asynchronously. While `rst`=0, register reads return 0 and writes are blocked.
- On reset release, the first write takes effect at the next rising edge.
- No handshake beyond the `ifu_valid` qualification.

## Structure
- Shared package holds:
  - opcode, funct3 and funct7 constants;
  - ALU-op enum;
  - load/store/branch/CSR-flag encodings;
  - the mcause value for ecall.
- One sub-module: `rv32_regfile` (32×32, 2 read ports, 1 write port, async active-low clear).
- Decode, immediate generation, ALU and branch compare stay in the top module.

## Test plan
- Reset, then `addi x1,x0,5`, then `add x2,x1,x1` → `alu_result_o`=5, then 10 after write-back. Reading x0 after writing x0=7 gives 0.
- `beq x1,x1,-8` at pc 0x80000010 → `branch_request_o`=1, target 0x80000008. `bltu` with rs1=0xFFFFFFFF, rs2=1 → 0.
- `jalr x1,4(x2)` with x2=0x80000003 at pc 0x80000000 → `jmp_target_o`=0x80000006, `alu_result_o`=0x80000004.
- `sw x3,8(x4)` with x4=0x100 → `mem_wen_o`=1, `alu_result_o`=0x108, `store_type_o`=3, `wd_o`=0. `lhu` → `load_type_o`=5.
- csrrs with `csr_rdata_i`=0xF0, rs1=0x0F → `csr_wdata_o`=0xFF, `alu_result_o`=0xF0. ecall → `csr_flag_o`=100, `csr_mcause_o`=11.
- `ifu_valid`=0 with a store → no side-effect outputs. Opcode 0x7F → `invalid_o`=1. Async reset mid-run → all registers read 0.
